// File: rtl/rca_pkg.sv
// Shared types and default sizing for the sequenced ripple-carry adder.
package rca_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int WIDTH_DEF = 64;
    localparam int SLICE_DEF = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N     = WIDTH_DEF / SLICE_DEF;
    localparam int IDX_W = idx_w(N);

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE-bit ripple-carry adder built from a chain of full adders.
module rca_slice
    import rca_pkg::*;
#(
    parameter int SLICE = SLICE_DEF
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out
);

    logic [SLICE:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[SLICE];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared rca_slice is stepped over WIDTH/SLICE
// cycles with a registered carry between slices, valid/ready on both sides.
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NS = WIDTH / SLICE;
    localparam int IW = idx_w(NS);

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("rca_seq_ctrl: WIDTH must be a multiple of SLICE");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d;
    logic [IW-1:0]     idx_q, idx_d;

    logic [SLICE-1:0]  sl_a, sl_b, sl_s;
    logic              sl_co;
    int                sh;

    // Slice selection by shift keeps the index width independent of N (N = 1 included).
    assign sh   = SLICE * int'(idx_q);
    assign sl_a = SLICE'(a_q >> sh);
    assign sl_b = SLICE'(b_q >> sh);

    rca_slice #(.SLICE(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry_q),
        .sum   (sl_s),
        .c_out (sl_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(WIDTH'({SLICE{1'b1}}) << sh)) | (WIDTH'(sl_s) << sh);
                carry_d = sl_co;
                if (idx_q == IW'(NS - 1)) begin
                    cout_d  = sl_co;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign res_valid   = (state_q == DONE);
    assign sum         = sum_q;
    assign c_out       = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and back-to-back random checks of the sequenced ripple-carry adder.
module tb_rca_seq_ctrl;

    localparam int W = 64;
    localparam int S = 16;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    rca_seq_ctrl #(.WIDTH(W), .SLICE(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .c_out       (c_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string nm, output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!res_valid) begin
            errors++;
            checks++;
            $display("FAIL %s.timeout: got no res_valid expected res_valid within 20 cycles", nm);
        end
    endtask

    task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ci,
                         input logic [W-1:0] es, input logic ec, input int hold, input string nm);
        int lat;
        chk({nm, ".start_ready"}, W'(start_ready), W'(1));
        a = aa; b = bb; c_in = ci; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        wait_result(nm, lat);
        chk({nm, ".latency"}, W'(lat), W'(N));
        chk({nm, ".sum"}, sum, es);
        chk({nm, ".c_out"}, W'(c_out), W'(ec));
        for (int h = 0; h < hold; h++) begin
            step();
            chk({nm, ".hold_sum"}, sum, es);
            chk({nm, ".hold_cout"}, W'(c_out), W'(ec));
            chk({nm, ".hold_valid"}, W'(res_valid), W'(1));
            chk({nm, ".hold_start_ready"}, W'(start_ready), W'(0));
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({nm, ".post_valid"}, W'(res_valid), W'(0));
        chk({nm, ".post_start_ready"}, W'(start_ready), W'(1));
    endtask

    initial begin
        int lat;
        int nres;
        int last;
        logic [W:0] e;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1};
        tbl[1] = '{64'd500000, 64'd1, 1'b1, 64'd500002, 1'b0};
        tbl[2] = '{64'd500000, 64'd1, 1'b0, 64'd500001, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        tbl[4] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        tbl[6] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};
        tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[8] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};

        repeat (2) step();
        rst_n = 1'b1;
        chk("reset.start_ready", W'(start_ready), W'(1));
        chk("reset.res_valid", W'(res_valid), W'(0));
        chk("reset.busy", W'(busy), W'(0));
        chk("reset.sum", sum, '0);
        chk("reset.c_out", W'(c_out), W'(0));

        // start_valid low must not start anything
        step();
        chk("idle.no_start", W'(busy), W'(0));

        for (int i = 0; i < 9; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, 0, $sformatf("vec%0d", i));

        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h1, 1'b1, 5, "backpressure");

        // new operands offered while RUN must be ignored
        a = 64'd100; b = 64'd23; c_in = 1'b0; start_valid = 1'b1;
        step();
        chk("busy_rej.busy", W'(busy), W'(1));
        a = 64'hDEAD; b = 64'hBEEF; c_in = 1'b1;
        step();
        chk("busy_rej.start_ready", W'(start_ready), W'(0));
        step();
        start_valid = 1'b0;
        wait_result("busy_rej", lat);
        chk("busy_rej.sum", sum, 64'd123);
        chk("busy_rej.c_out", W'(c_out), W'(0));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        nres = 0;
        repeat (6) begin
            step();
            if (res_valid) nres++;
        end
        chk("busy_rej.extra_results", W'(nres), W'(0));

        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; c_in = 1'b1; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset.busy", W'(busy), W'(0));
        chk("midreset.res_valid", W'(res_valid), W'(0));
        chk("midreset.start_ready", W'(start_ready), W'(1));
        chk("midreset.sum", sum, '0);
        chk("midreset.c_out", W'(c_out), W'(0));
        do_op(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 0, "after_reset");

        res_ready = 1'b1;
        start_valid = 1'b1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
        last = 0;
        for (int i = 0; i < 1000; i++) begin
            e = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
            step();
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'($urandom);
            wait_result("b2b", lat);
            if (!res_valid) break;
            chk("b2b.sum", sum, e[W-1:0]);
            chk("b2b.c_out", W'(c_out), W'(e[W]));
            if (i > 0) chk("b2b.spacing", W'(cyc - last), W'(N + 2));
            last = cyc;
            step();
        end
        start_valid = 1'b0;
        res_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
